ram4k_dma: RTL and testbench

Bus-master block-copy/fill engine that drives the ram4k memory port (address, in, load; reads out). The RAM is the responder and this block is the initiator. It moves or initialises blocks of 16-bit words without CPU involvement. It sits beside the CPU on the memory port, and an external arbiter grants the port while busy=1.

---
 rtl/ram4k_dma.sv | 110 +++++++++++
 tb/tb_ram4k_dma.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram4k_dma.sv
// rtl/ram4k_dma.sv - block copy/fill bus master for the ram4k memory port
module ram4k_dma #(
    parameter int AW = 12,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW:0]   len,
    input  logic [DW-1:0] fill_value,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_load,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] src_ptr;
    logic [AW-1:0] dst_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_dec;
    logic          mode_r;
    // Holds the word to be written: the fill value in fill mode, the last
    // read word in copy mode. It is only updated on start or a read, so it
    // keeps its value between writes.
    logic [DW-1:0] wdata_r;

    assign count_dec = count - (AW+1)'(1);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; a zero-length request goes straight to FINISH
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0)  state_next = FINISH;
                    else if (mode)  state_next = WRITE;
                    else            state_next = READ;
                end
            end
            READ:   state_next = WRITE;
            WRITE: begin
                if (count_dec == '0) state_next = FINISH;
                else if (mode_r)     state_next = WRITE;
                else                 state_next = READ;
            end
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pointers, word count and write buffer; pointers wrap modulo 2^AW
    always_ff @(posedge clk) begin
        if (reset) begin
            src_ptr <= '0;
            dst_ptr <= '0;
            count   <= '0;
            mode_r  <= 1'b0;
            wdata_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr <= src;
                        dst_ptr <= dst;
                        count   <= len;
                        mode_r  <= mode;
                        if (mode) wdata_r <= fill_value;
                    end
                end
                READ: begin
                    wdata_r <= ram_rdata;
                    src_ptr <= src_ptr + AW'(1);
                end
                WRITE: begin
                    dst_ptr <= dst_ptr + AW'(1);
                    count   <= count_dec;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        busy        = (state == READ) || (state == WRITE);
        done        = (state == FINISH);
        ram_load    = (state == WRITE);
        ram_address = (state == WRITE) ? dst_ptr : src_ptr;
        ram_wdata   = wdata_r;
    end

endmodule

// File: tb/tb_ram4k_dma.sv
// tb/tb_ram4k_dma.sv - randomized self-checking bench for ram4k_dma
module tb_ram4k_dma;
    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] src = '0;
    logic [AW-1:0] dst = '0;
    logic [AW:0]   len = '0;
    logic [DW-1:0] fill_value = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_wdata;
    logic          ram_load;
    logic [DW-1:0] ram_rdata;

    logic [DW-1:0] mem     [0:4095];
    logic [DW-1:0] ref_mem [0:4095];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit            busy;
        bit            load;
        bit            done;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } exp_t;
    exp_t q[$];

    ram4k_dma #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .src(src), .dst(dst), .len(len), .fill_value(fill_value),
        .busy(busy), .done(done), .ram_address(ram_address),
        .ram_wdata(ram_wdata), .ram_load(ram_load), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM responder: combinational read, write at the rising edge
    assign ram_rdata = mem[ram_address];
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (ram_load) mem[ram_address] <= ram_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int count_diffs();
        int n = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d; ref_mem[a] = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic compare_cycle(input exp_t e);
        chk("busy", busy, e.busy);
        chk("done", done, e.done);
        chk("ram_load", ram_load, e.load);
        if (e.busy) chk("ram_address", ram_address, e.addr);
        if (e.load) chk("ram_wdata", ram_wdata, e.wdata);
    endtask

    // Model: a transfer is the ascending word loop dst[i] = src[i] (or fill),
    // applied to the reference memory; each word contributes its bus cycles.
    task automatic run(input bit m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                       input logic [AW:0] n, input logic [DW-1:0] f, input bit glitch);
        exp_t          e;
        logic [AW-1:0] a_s;
        logic [AW-1:0] a_d;
        logic [DW-1:0] v;
        q.delete();
        for (int i = 0; i < int'(n); i++) begin
            a_s = s + AW'(i);
            a_d = d + AW'(i);
            if (!m) begin
                v = ref_mem[a_s];
                e = '{1'b1, 1'b0, 1'b0, a_s, '0};
                q.push_back(e);
            end else begin
                v = f;
            end
            ref_mem[a_d] = v;
            e = '{1'b1, 1'b1, 1'b0, a_d, v};
            q.push_back(e);
        end
        e = '{1'b0, 1'b0, 1'b1, '0, '0};
        q.push_back(e);
        e = '{1'b0, 1'b0, 1'b0, '0, '0};
        q.push_back(e);
        @(negedge clk);
        mode = m; src = s; dst = d; len = n; fill_value = f; start = 1'b1;
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            start = (k == 0) && glitch;
            mode = 1'($urandom); src = AW'($urandom); dst = AW'($urandom);
            len = (AW+1)'($urandom_range(1, 8)); fill_value = DW'($urandom);
            compare_cycle(q[k]);
        end
        start = 1'b0;
        chk("memory_diffs", count_diffs(), 0);
    endtask

    initial begin
        logic [AW-1:0] rs;
        logic [AW:0]   rl;
        reset = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            @(negedge clk);
            pre_we = 1'b1; pre_addr = AW'(i); pre_data = DW'($urandom);
            ref_mem[i] = pre_data;
        end
        @(negedge clk);
        pre_we = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_load", ram_load, 0);
        chk("reset_addr", ram_address, 0);
        chk("reset_wdata", ram_wdata, 0);
        reset = 1'b0;

        // Fill 4 words at 0
        poke(12'h004, 16'h5555);
        run(1'b1, 12'h000, 12'h000, 13'd4, 16'hABAB, 1'b0);
        for (int i = 0; i < 4; i++) chk("fill_word", mem[i], 16'hABAB);
        chk("fill_untouched", mem[4], 16'h5555);

        // Copy 3 words
        poke(12'h010, 16'h1111); poke(12'h011, 16'h2222); poke(12'h012, 16'h3333);
        run(1'b0, 12'h010, 12'h100, 13'd3, 16'h0, 1'b0);
        chk("copy_0", mem[12'h100], 16'h1111);
        chk("copy_1", mem[12'h101], 16'h2222);
        chk("copy_2", mem[12'h102], 16'h3333);

        // Address wrap
        poke(12'h002, 16'h7777);
        run(1'b1, 12'h000, 12'hFFE, 13'd4, 16'hCDCD, 1'b0);
        chk("wrap_ffe", mem[12'hFFE], 16'hCDCD);
        chk("wrap_fff", mem[12'hFFF], 16'hCDCD);
        chk("wrap_000", mem[12'h000], 16'hCDCD);
        chk("wrap_001", mem[12'h001], 16'hCDCD);
        chk("wrap_untouched", mem[12'h002], 16'h7777);

        // Zero length, and starts issued while busy
        run(1'b1, 12'h050, 12'h060, 13'd0, 16'h1234, 1'b1);
        run(1'b1, 12'h070, 12'h080, 13'd5, 16'h4321, 1'b1);
        run(1'b0, 12'h090, 12'h0A0, 13'd3, 16'h0, 1'b1);

        // Overlapping copy propagates
        poke(12'h020, 16'h0001); poke(12'h021, 16'h0002);
        run(1'b0, 12'h020, 12'h021, 13'd2, 16'h0, 1'b0);
        chk("overlap_21", mem[12'h021], 16'h0001);
        chk("overlap_22", mem[12'h022], 16'h0001);

        // Reset during the second write of a 4-word copy
        for (int i = 0; i < 4; i++) begin
            poke(12'h300 + AW'(i), 16'hA000 + DW'(i));
            poke(12'h400 + AW'(i), 16'hB000 + DW'(i));
        end
        @(negedge clk);
        mode = 1'b0; src = 12'h300; dst = 12'h400; len = 13'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_second_write_load", ram_load, 1);
        chk("rst_second_write_addr", ram_address, 12'h401);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_load", ram_load, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("rst_no_done", done, 0);
            chk("rst_no_load", ram_load, 0);
        end
        ref_mem[12'h400] = 16'hA000;
        ref_mem[12'h401] = 16'hA001;
        chk("rst_w0", mem[12'h400], 16'hA000);
        chk("rst_w1", mem[12'h401], 16'hA001);
        chk("rst_w2", mem[12'h402], 16'hB002);
        chk("rst_w3", mem[12'h403], 16'hB003);
        chk("rst_memory_diffs", count_diffs(), 0);

        // Randomized transfers, biased towards overlapping copies
        for (int t = 0; t < 24; t++) begin
            rs = AW'($urandom);
            rl = (AW+1)'($urandom_range(0, 24));
            if (t % 2 == 0)
                run(1'b0, rs, rs + AW'($urandom_range(0, 3)), rl, 16'h0, 1'($urandom));
            else
                run(1'($urandom), rs, AW'($urandom), rl, DW'($urandom), 1'($urandom));
        end

        // Full-memory fill
        run(1'b1, 12'h000, AW'($urandom), 13'd4096, 16'h5A5A, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
